// File: rtl/rat_mc.sv
// rat_mc: multi-lane register alias table with a managed checkpoint ring.
//
// Renames up to RN_WIDTH destinations per cycle and takes one map checkpoint
// per branch lane in an accepted bundle. Checkpoints live in a ring (head =
// oldest, tail = next allocation). They are released oldest-first. A restore
// of a live checkpoint reloads the map and frees that slot and all younger ones.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   i_rn_valid       per-lane rename write enable
//   i_rn_laddr       per-lane destination logical register
//   i_rn_paddr       per-lane newly allocated physical register
//   i_rn_branch      per-lane checkpoint request
//   i_rd_laddr       two source logical registers per lane (2k, 2k+1)
//   o_rd_paddr       mapped physical registers for the sources
//   o_ckp_ready      enough free slots for this bundle's branches
//   o_ckp_id         slot assigned to each branch lane
//   o_ckp_count      number of live checkpoints
//   i_ckp_release    oldest checkpoint resolved; free it
//   i_restore        mispredict; restore the map from i_restore_id
//   i_restore_id     checkpoint to restore
//
// Build option: define RAT_BYPASS_EN to forward older-lane writes in the same
// bundle to younger-lane sources.
module rat_mc #(
   parameter int unsigned P_ADDR_WIDTH = 7,
   parameter int unsigned L_ADDR_WIDTH = 5,
   parameter int unsigned C_NUM        = 4,
   parameter int unsigned RN_WIDTH     = 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [RN_WIDTH-1:0]                    i_rn_valid,
   input  logic [RN_WIDTH*L_ADDR_WIDTH-1:0]       i_rn_laddr,
   input  logic [RN_WIDTH*P_ADDR_WIDTH-1:0]       i_rn_paddr,
   input  logic [RN_WIDTH-1:0]                    i_rn_branch,
   input  logic [2*RN_WIDTH*L_ADDR_WIDTH-1:0]     i_rd_laddr,
   output logic [2*RN_WIDTH*P_ADDR_WIDTH-1:0]     o_rd_paddr,
   output logic                                   o_ckp_ready,
   output logic [RN_WIDTH*$clog2(C_NUM)-1:0]      o_ckp_id,
   output logic [$clog2(C_NUM):0]                 o_ckp_count,
   input  logic                                   i_ckp_release,
   input  logic                                   i_restore,
   input  logic [$clog2(C_NUM)-1:0]               i_restore_id
);

   localparam int unsigned CID    = $clog2(C_NUM);
   localparam int unsigned CW     = CID + 1;
   localparam int unsigned L_REGS = 2 ** L_ADDR_WIDTH;

   logic [P_ADDR_WIDTH-1:0] r_rat [L_REGS];
   logic [P_ADDR_WIDTH-1:0] r_ckp [C_NUM][L_REGS];
   logic [CID-1:0]          r_head;
   logic [CID-1:0]          r_tail;
   logic [CW-1:0]           r_count;

   // w_snap[k] is the map with lanes 0..k applied; the last one is the next map.
   logic [P_ADDR_WIDTH-1:0] w_snap [RN_WIDTH][L_REGS];
   int unsigned             w_nb;
   logic                    w_accept;
   logic                    w_rel;
   logic                    w_rel_eff;
   logic [CID-1:0]          w_dist;
   logic                    w_live;
   logic [CID-1:0]          w_head_nxt;

   always_comb begin
      logic [P_ADDR_WIDTH-1:0] w_map;
      for (int i = 0; i < int'(L_REGS); i++) begin
         w_map = r_rat[i];
         for (int k = 0; k < int'(RN_WIDTH); k++) begin
            if (i_rn_valid[k] && (i_rn_laddr[k*L_ADDR_WIDTH +: L_ADDR_WIDTH] ==
                                  L_ADDR_WIDTH'(i))) begin
               w_map = i_rn_paddr[k*P_ADDR_WIDTH +: P_ADDR_WIDTH];
            end
            w_snap[k][i] = w_map;
         end
      end
   end

   // Slot of branch lane k = tail + number of branches in older lanes.
   always_comb begin
      int unsigned w_cnt;
      w_cnt = 0;
      for (int k = 0; k < int'(RN_WIDTH); k++) begin
         o_ckp_id[k*CID +: CID] = r_tail + CID'(w_cnt);
         if (i_rn_branch[k]) w_cnt = w_cnt + 1;
      end
      w_nb = w_cnt;
   end

   always_comb begin
      o_ckp_ready = (C_NUM - 32'(r_count)) >= w_nb;
      w_accept    = o_ckp_ready & ~i_restore;
      w_rel       = i_ckp_release & (r_count != '0);
      w_dist      = i_restore_id - r_head;
      w_live      = i_restore & ({1'b0, w_dist} < r_count);
      // Restoring the oldest slot frees everything, so the release has nothing left.
      w_rel_eff   = w_rel & ~(w_live & (i_restore_id == r_head));
      w_head_nxt  = r_head + CID'(w_rel_eff);
      o_ckp_count = r_count;
   end

   always_comb begin
      logic [L_ADDR_WIDTH-1:0] w_la;
      logic [P_ADDR_WIDTH-1:0] w_pa;
      for (int j = 0; j < int'(2 * RN_WIDTH); j++) begin
         w_la = i_rd_laddr[j*L_ADDR_WIDTH +: L_ADDR_WIDTH];
         w_pa = r_rat[w_la];
`ifdef RAT_BYPASS_EN
         for (int l = 0; l < j / 2; l++) begin
            if (i_rn_valid[l] && (i_rn_laddr[l*L_ADDR_WIDTH +: L_ADDR_WIDTH] == w_la)) begin
               w_pa = i_rn_paddr[l*P_ADDR_WIDTH +: P_ADDR_WIDTH];
            end
         end
`endif
         o_rd_paddr[j*P_ADDR_WIDTH +: P_ADDR_WIDTH] = w_pa;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(L_REGS); i++) r_rat[i] <= P_ADDR_WIDTH'(i);
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (w_live) begin
         r_rat   <= r_ckp[i_restore_id];
         r_head  <= w_head_nxt;
         r_tail  <= i_restore_id;
         r_count <= {1'b0, i_restore_id - w_head_nxt};
      end else begin
         r_head <= w_head_nxt;
         if (w_accept) begin
            r_rat   <= w_snap[RN_WIDTH-1];
            r_tail  <= r_tail + CID'(w_nb);
            r_count <= r_count + CW'(w_nb) - CW'(w_rel_eff);
         end else begin
            r_count <= r_count - CW'(w_rel_eff);
         end
      end
   end

   // Checkpoint storage is deliberately not reset; only live slots are ever read.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int k = 0; k < int'(RN_WIDTH); k++) begin
            if (i_rn_branch[k]) r_ckp[o_ckp_id[k*CID +: CID]] <= w_snap[k];
         end
      end
   end

endmodule
